// File: rtl/aes_result_fifo.sv
// Result buffer behind the pipelined AES core: FWFT FIFO drained by valid/ready,
// plus an in-flight counter that grants issue credit so results never meet a full buffer.
module aes_result_fifo #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_in,
  output logic              credit_ok,
  input  logic              core_valid_in,
  input  logic [DATA_W-1:0] core_data_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   inflight,
  output logic              overflow_err,
  output logic              protocol_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W+1:0] CRED_LIM = {2'b01, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   inflight_q, inflight_d;
  logic              ovf_q, ovf_d;
  logic              prot_q, prot_d;

  logic empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign pop   = !empty && out_ready;
  // A pop frees the head slot in the same edge, so a full FIFO still accepts.
  assign push  = core_valid_in && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q;
    ovf_d      = ovf_q;
    prot_d     = prot_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (core_valid_in && !push) ovf_d = 1'b1;

    case ({issue_in, core_valid_in})
      2'b10: if (inflight_q != CNT_MAX) inflight_d = inflight_q + 1'b1;
      2'b01: if (inflight_q != '0)      inflight_d = inflight_q - 1'b1;
      default: ;
    endcase

    if (issue_in && !credit_ok) prot_d = 1'b1;
    if (core_valid_in && !issue_in && (inflight_q == '0)) prot_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
      ovf_q      <= 1'b0;
      prot_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
      prot_q     <= prot_d;
    end
  end

  // Storage is deliberately not reset; out_data gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[ADDR_W-1:0]] <= core_data_in;
  end

  assign count        = wr_ptr_q - rd_ptr_q;
  assign inflight     = inflight_q;
  assign out_valid    = !empty;
  assign out_data     = out_valid ? mem[rd_ptr_q[ADDR_W-1:0]] : '0;
  assign credit_ok    = ({1'b0, count} + {1'b0, inflight_q}) < CRED_LIM;
  assign overflow_err = ovf_q;
  assign protocol_err = prot_q;
endmodule

// File: tb/tb_aes_result_fifo.sv
// Directed bench for aes_result_fifo: reset, single block, credit exhaustion,
// full push+pop, overflow and protocol error scenarios.
module tb_aes_result_fifo;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_in;
  logic              credit_ok;
  logic              core_valid_in;
  logic [DATA_W-1:0] core_data_in;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   inflight;
  logic              overflow_err;
  logic              protocol_err;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [DATA_W-1:0] KAT = 128'h3925841D02DC09FBDC118597196A0B32;

  aes_result_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .issue_in(issue_in), .credit_ok(credit_ok),
    .core_valid_in(core_valid_in), .core_data_in(core_data_in),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .inflight(inflight),
    .overflow_err(overflow_err), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " out_valid"}, DATA_W'(out_valid), '0);
    chk({tag, " out_data"},  out_data, '0);
    chk({tag, " count"},     DATA_W'(count), '0);
    chk({tag, " inflight"},  DATA_W'(inflight), '0);
    chk({tag, " credit_ok"}, DATA_W'(credit_ok), 1);
    chk({tag, " overflow"},  DATA_W'(overflow_err), '0);
    chk({tag, " protocol"},  DATA_W'(protocol_err), '0);
  endtask

  initial begin
    reset = 1'b1; issue_in = 1'b0; core_valid_in = 1'b0;
    core_data_in = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_reset_state("init");

    // Single block round trip
    issue_in = 1'b1; tick(); issue_in = 1'b0;
    chk("single inflight", DATA_W'(inflight), 1);
    repeat (20) tick();
    core_valid_in = 1'b1; core_data_in = KAT; tick(); core_valid_in = 1'b0;
    chk("single inflight0", DATA_W'(inflight), 0);
    chk("single count", DATA_W'(count), 1);
    chk("single valid", DATA_W'(out_valid), 1);
    chk("single data", out_data, KAT);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("single empty", DATA_W'(out_valid), 0);
    chk("single count0", DATA_W'(count), 0);

    // Credit exhaustion: 16 issues, then 16 results 0..15
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("credit before 16th", DATA_W'(credit_ok), 1);
      issue_in = 1'b1; tick();
    end
    issue_in = 1'b0;
    chk("credit after 16", DATA_W'(credit_ok), 0);
    chk("inflight 16", DATA_W'(inflight), 16);
    for (int i = 0; i < 16; i++) begin
      core_valid_in = 1'b1; core_data_in = DATA_W'(i); tick();
    end
    core_valid_in = 1'b0;
    chk("full count", DATA_W'(count), 16);
    chk("full inflight", DATA_W'(inflight), 0);
    chk("full credit", DATA_W'(credit_ok), 0);
    chk("full head", out_data, 0);
    chk("full protocol", DATA_W'(protocol_err), 0);

    // Issue without credit
    issue_in = 1'b1; tick(); issue_in = 1'b0;
    chk("nocredit protocol", DATA_W'(protocol_err), 1);
    chk("nocredit inflight", DATA_W'(inflight), 1);

    // Push 16 and pop simultaneously while full
    core_valid_in = 1'b1; core_data_in = DATA_W'(16); out_ready = 1'b1;
    chk("pushpop pop value", out_data, 0);
    tick();
    core_valid_in = 1'b0; out_ready = 1'b0;
    chk("pushpop count", DATA_W'(count), 16);
    chk("pushpop overflow", DATA_W'(overflow_err), 0);
    chk("pushpop inflight", DATA_W'(inflight), 0);
    chk("pushpop credit", DATA_W'(credit_ok), 0);

    // One pop frees credit next cycle
    out_ready = 1'b1;
    chk("drain 1", out_data, 1);
    tick(); out_ready = 1'b0;
    chk("pop credit", DATA_W'(credit_ok), 1);
    chk("pop count", DATA_W'(count), 15);

    out_ready = 1'b1;
    for (int v = 2; v <= 16; v++) begin
      chk($sformatf("drain %0d", v), out_data, DATA_W'(v));
      tick();
    end
    out_ready = 1'b0;
    chk("drain empty", DATA_W'(out_valid), 0);
    chk("drain count", DATA_W'(count), 0);

    // Overflow: refill with A0..AF, then push 99 while full with no pop
    for (int i = 0; i < 16; i++) begin
      issue_in = 1'b1; tick();
    end
    issue_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      core_valid_in = 1'b1; core_data_in = DATA_W'(8'hA0 + i); tick();
    end
    core_data_in = DATA_W'(99); tick();
    core_valid_in = 1'b0;
    chk("ovf flag", DATA_W'(overflow_err), 1);
    chk("ovf count", DATA_W'(count), 16);
    chk("ovf head", out_data, DATA_W'(8'hA0));
    tick();
    chk("ovf sticky", DATA_W'(overflow_err), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf drain %0d", i), out_data, DATA_W'(8'hA0 + i));
      tick();
    end
    out_ready = 1'b0;
    chk("ovf drain empty", DATA_W'(out_valid), 0);
    chk("ovf drain data", out_data, '0);

    // Mid-traffic reset
    for (int i = 0; i < 3; i++) begin
      issue_in = 1'b1; tick();
    end
    issue_in = 1'b0;
    core_valid_in = 1'b1; core_data_in = DATA_W'(7); tick(); core_valid_in = 1'b0;
    chk("pre-reset count", DATA_W'(count), 1);
    chk("pre-reset inflight", DATA_W'(inflight), 2);
    reset = 1'b1; issue_in = 1'b1; tick(); tick();
    reset = 1'b0; issue_in = 1'b0;
    chk_reset_state("midreset");

    // Core result with nothing in flight
    core_valid_in = 1'b1; core_data_in = DATA_W'(128'h55); tick(); core_valid_in = 1'b0;
    chk("stray protocol", DATA_W'(protocol_err), 1);
    chk("stray inflight", DATA_W'(inflight), 0);
    chk("stray count", DATA_W'(count), 1);
    chk("stray data", out_data, DATA_W'(128'h55));
    tick();
    chk("stray sticky", DATA_W'(protocol_err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_result_fifo.md
# aes_result_fifo

Output buffering and credit stage placed directly downstream of the pipelined AES-128 cipher. The cipher core has no back-pressure: once a block is issued, its ciphertext appears a fixed number of cycles later whether or not anyone is ready. This block solves that in two ways. It captures every ciphertext the core emits into a first-word-fall-through FIFO drained through a valid/ready handshake. It also tells the issuing logic when a new block may be sent (`credit_ok`), by counting blocks still in flight inside the core. Together these guarantee a result can never arrive to a full buffer.

## Interface
Parameters:
- `DATA_W`, 128, ciphertext width.
- `ADDR_W`, 4, FIFO address width; DEPTH = 2**ADDR_W (16).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `issue_in`  in  1  pulses in the same cycle the issuer drives the core's data-valid input (one block issued).
- `credit_ok`  out  1  a block may be issued this cycle.
- `core_valid_in`  in  1  core output-valid.
- `core_data_in`  in  DATA_W  core ciphertext.
- `out_valid`  out  1  head entry available.
- `out_data`  out  DATA_W  head entry; all zero when `out_valid`=0.
- `out_ready`  in  1  consumer accepts the head entry.
- `count`  out  ADDR_W+1  FIFO occupancy, 0..DEPTH.
- `inflight`  out  ADDR_W+1  blocks issued but not yet returned by the core, 0..DEPTH.
- `overflow_err`  out  1  sticky; a result was dropped because the FIFO was full.
- `protocol_err`  out  1  sticky; either issue without credit, or a core result with `inflight`=0.

## Operation
Storage and pointers:
- Storage is DEPTH x DATA_W registers.
- `wr_ptr` and `rd_ptr` are each ADDR_W+1 bits: the low ADDR_W bits address storage, the MSB is a wrap bit.
- Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- `count` = `wr_ptr` - `rd_ptr`, modulo 2**(ADDR_W+1).

Push:
- Occurs when `core_valid_in`=1 and (not full, or a pop happens the same cycle).
- Writes `mem[wr_ptr]` and increments `wr_ptr`.
- `core_valid_in`=1 while full with no pop: the data is dropped, pointers are unchanged, and `overflow_err` is set to 1.

Pop:
- Occurs when `out_valid`=1 and `out_ready`=1; increments `rd_ptr`.
- `out_valid` = not empty.
- `out_data` = `mem[rd_ptr]` gated by `out_valid`.

Simultaneous push and pop:
- When full: both take effect. The read returns the old head, the write lands in the slot being freed, and `count` stays DEPTH.
- When empty: only the push occurs, since `out_valid`=0 means no pop.

`inflight` counter:
- +1 on `issue_in`; -1 on `core_valid_in`; both in the same cycle leaves it unchanged.
- Saturates at DEPTH and at 0.
- `issue_in`=1 while `credit_ok`=0 sets `protocol_err`. The counter still increments unless it is already at DEPTH.
- `core_valid_in`=1 with `inflight`=0 and no same-cycle `issue_in` sets `protocol_err`. The counter stays at 0, but the data is still pushed.

Credit:
- `credit_ok` = (`count` + `inflight`) < DEPTH.
- Computed combinationally from registered state with an ADDR_W+2-bit sum.
- Does not depend on same-cycle `issue_in`, `out_ready` or `core_valid_in`.

Error flags: both are sticky and clear only on `reset`.

## Timing
- Reset (synchronous, `reset`=1 at an edge) clears the pointers, `inflight` and both error flags. In the following cycle: `out_valid`=0, `out_data`=0, `count`=0, `inflight`=0, `credit_ok`=1, errors = 0. Storage contents are not cleared.
- Reset asserted mid-stream discards all buffered and in-flight accounting. Core results arriving after reset while `inflight`=0 flag `protocol_err`. Reset of the core and of this block must therefore be common.
- Push latency: `core_valid_in` at edge N makes `out_valid`=1 with that data after edge N, i.e. one cycle. There is no combinational path from `core_valid_in` to `out_valid`.
- Pop frees credit one cycle later: a pop at edge N lowers `count` after N.
- Back-to-back push and pop at full rate sustains 1 block/cycle.
- `out_data` holds stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-traffic -> next cycle `out_valid`=0, `out_data`=0, `count`=0, `inflight`=0, `credit_ok`=1, both errors = 0.
- **Single block:** `issue_in` pulse (`inflight`->1); 21 cycles later `core_valid_in` with 128'h3925841D02DC09FBDC118597196A0B32 -> `inflight`=0, `count`=1, `out_valid`=1 with that value; `out_ready`=1 for one cycle -> empty.
- **Credit exhaustion:** `out_ready`=0; issue 16 blocks -> `credit_ok`=0 after the 16th. Return 16 results -> `count`=16, `inflight`=0, `credit_ok`=0. One pop -> `credit_ok`=1 the next cycle.
- **Full with push and pop:** FIFO full (16, values 0..15); push 16 and pop in the same cycle -> pop returns 0, `count`=16, and the last entry read out is 16; `overflow_err`=0.
- **Overflow:** FIFO full, `out_ready`=0, push 99 -> `overflow_err`=1 (sticky), `count`=16, and 99 never appears at `out_data`.
- **Protocol errors:** `issue_in` with `credit_ok`=0 -> `protocol_err`=1. After reset, `core_valid_in` with `inflight`=0 -> `protocol_err`=1, the data is buffered, and `inflight` stays 0.
